// File: rtl/if_stage_if.sv
// if_stage_if: control, ROM and IF/ID signals of the instruction-fetch stage
interface if_stage_if #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 64
);
    logic              stall_if_i;
    logic              stall_id_i;
    logic              flush_i;
    logic [ADDR_W-1:0] flush_pc_i;
    logic              branch_i;
    logic [ADDR_W-1:0] branch_target_i;
    logic [INST_W-1:0] inst_i;
    logic              ce_o;
    logic [ADDR_W-1:0] pc_o;
    logic [ADDR_W-1:0] id_pc_o;
    logic [INST_W-1:0] id_inst_o;
    logic              id_valid_o;

    modport slave (
        input  stall_if_i, stall_id_i, flush_i, flush_pc_i, branch_i, branch_target_i, inst_i,
        output ce_o, pc_o, id_pc_o, id_inst_o, id_valid_o
    );

    modport master (
        output stall_if_i, stall_id_i, flush_i, flush_pc_i, branch_i, branch_target_i, inst_i,
        input  ce_o, pc_o, id_pc_o, id_inst_o, id_valid_o
    );
endinterface

// File: rtl/if_stage.sv
// if_stage: program counter, ROM addressing and IF/ID pipeline latch
module if_stage #(
    parameter int                ADDR_W   = 32,
    parameter int                INST_W   = 64,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic      clk,
    input  logic      rst_n,
    if_stage_if.slave bus
);
    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(INST_W / 8);
    localparam logic [ADDR_W-1:0] ALIGN_M = ~ADDR_W'(7);

    logic              r_ce;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_id_pc;
    logic [INST_W-1:0] r_id_inst;
    logic              r_id_valid;
    logic [ADDR_W-1:0] w_pc_nxt;
    logic              w_hold;
    logic              w_bubble;

    assign bus.ce_o       = r_ce;
    assign bus.pc_o       = r_pc;
    assign bus.id_pc_o    = r_id_pc;
    assign bus.id_inst_o  = r_id_inst;
    assign bus.id_valid_o = r_id_valid;

    // Next PC: flush beats stall, stall beats branch; PC parks at RESET_PC until fetch is enabled
    always_comb begin
        w_pc_nxt = r_pc;
        if (r_ce) begin
            if (bus.flush_i)
                w_pc_nxt = bus.flush_pc_i & ALIGN_M;
            else if (!bus.stall_if_i)
                w_pc_nxt = bus.branch_i ? (bus.branch_target_i & ALIGN_M) : r_pc + PC_STEP;
        end
        w_hold   = !bus.flush_i && bus.stall_id_i;
        w_bubble = bus.flush_i || bus.stall_if_i || bus.branch_i || !r_ce;
    end

    // State update: reset overrides everything; IF/ID either holds, takes a bubble, or captures the fetch
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ce       <= 1'b0;
            r_pc       <= RESET_PC;
            r_id_pc    <= '0;
            r_id_inst  <= '0;
            r_id_valid <= 1'b0;
        end else begin
            r_ce <= 1'b1;
            r_pc <= w_pc_nxt;
            if (!w_hold) begin
                r_id_valid <= !w_bubble;
                r_id_pc    <= w_bubble ? '0 : r_pc;
                r_id_inst  <= w_bubble ? '0 : bus.inst_i;
            end
        end
    end
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed checks of the fetch stage against a reference model of the pipeline rules
module tb_if_stage;
    localparam logic [63:0] ROM0 = 64'h2082000000320000;
    localparam logic [63:0] ROM1 = 64'h20e27ffffff60000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    bit   en_chk = 1'b0;

    logic        m_ce;
    logic [31:0] m_pc;
    logic [31:0] m_id_pc;
    logic [63:0] m_id_inst;
    logic        m_id_valid;

    if_stage_if #(.ADDR_W(32), .INST_W(64)) bus ();

    if_stage #(.ADDR_W(32), .INST_W(64), .RESET_PC(32'h0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] rom_word(input logic [31:0] a);
        if (a == 32'h0) return ROM0;
        if (a == 32'h8) return ROM1;
        return {a ^ 32'hA5A5_0000, ~a};
    endfunction

    assign bus.inst_i = rom_word(bus.pc_o);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one fetch per cycle, squashed by any redirect or fetch stall
    always @(posedge clk) begin
        logic [31:0] fetch_pc;
        logic        squash;
        if (!rst_n) begin
            m_ce = 1'b0; m_pc = 32'h0; m_id_pc = 32'h0; m_id_inst = 64'h0; m_id_valid = 1'b0;
        end else begin
            fetch_pc = m_pc;
            squash = bus.flush_i || bus.stall_if_i || bus.branch_i || !m_ce;
            if (bus.flush_i || !bus.stall_id_i) begin
                m_id_valid = !squash;
                m_id_pc    = squash ? 32'h0 : fetch_pc;
                m_id_inst  = squash ? 64'h0 : rom_word(fetch_pc);
            end
            if (m_ce) begin
                if (bus.flush_i) m_pc = {bus.flush_pc_i[31:3], 3'b000};
                else if (bus.stall_if_i) m_pc = fetch_pc;
                else if (bus.branch_i) m_pc = {bus.branch_target_i[31:3], 3'b000};
                else m_pc = fetch_pc + 32'd8;
            end
            m_ce = 1'b1;
        end
    end

    // Every cycle after the first reset edge, DUT outputs must equal the model
    always @(negedge clk) begin
        if (en_chk) begin
            chk("ce_o", 64'(bus.ce_o), 64'(m_ce));
            chk("pc_o", 64'(bus.pc_o), 64'(m_pc));
            chk("id_pc_o", 64'(bus.id_pc_o), 64'(m_id_pc));
            chk("id_inst_o", bus.id_inst_o, m_id_inst);
            chk("id_valid_o", 64'(bus.id_valid_o), 64'(m_id_valid));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic sif, input logic sid, input logic fl, input logic [31:0] fpc,
                          input logic br, input logic [31:0] bt);
        bus.stall_if_i = sif; bus.stall_id_i = sid; bus.flush_i = fl;
        bus.flush_pc_i = fpc; bus.branch_i = br; bus.branch_target_i = bt;
    endtask

    initial begin
        set_in(0, 0, 0, 0, 0, 0);
        step();
        en_chk = 1'b1;
        step();
        chk("rst ce", 64'(bus.ce_o), 64'd0);
        chk("rst pc", 64'(bus.pc_o), 64'd0);
        chk("rst inst", bus.id_inst_o, 64'd0);
        rst_n = 1'b1;
        step();
        chk("first ce", 64'(bus.ce_o), 64'd1);
        chk("first pc", 64'(bus.pc_o), 64'h0);
        chk("first valid", 64'(bus.id_valid_o), 64'd0);
        step();
        chk("seq pc8", 64'(bus.pc_o), 64'h8);
        chk("seq inst0", bus.id_inst_o, ROM0);
        chk("seq valid", 64'(bus.id_valid_o), 64'd1);
        step();
        chk("seq pc16", 64'(bus.pc_o), 64'h10);
        chk("seq inst1", bus.id_inst_o, ROM1);
        chk("seq idpc8", 64'(bus.id_pc_o), 64'h8);
        set_in(0, 0, 0, 0, 1, 32'h40);
        step();
        chk("br pc", 64'(bus.pc_o), 64'h40);
        chk("br bubble", 64'(bus.id_valid_o), 64'd0);
        set_in(0, 0, 0, 0, 0, 0);
        step();
        chk("br idpc", 64'(bus.id_pc_o), 64'h40);
        set_in(0, 0, 0, 0, 1, 32'h43);
        step();
        chk("br align pc", 64'(bus.pc_o), 64'h40);
        set_in(0, 0, 1, 32'h10, 0, 0);
        step();
        set_in(0, 0, 0, 0, 0, 0);
        step();
        chk("pre-stall pc", 64'(bus.pc_o), 64'h18);
        set_in(1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall pc", 64'(bus.pc_o), 64'h18);
            chk("stall idpc", 64'(bus.id_pc_o), 64'h10);
            chk("stall valid", 64'(bus.id_valid_o), 64'd1);
        end
        set_in(1, 0, 0, 0, 0, 0);
        step();
        chk("stall_if pc", 64'(bus.pc_o), 64'h18);
        chk("stall_if bubble", 64'(bus.id_valid_o), 64'd0);
        set_in(0, 0, 0, 0, 0, 0);
        step();
        chk("unstall idpc", 64'(bus.id_pc_o), 64'h18);
        set_in(1, 1, 1, 32'h100, 1, 32'h40);
        step();
        chk("flush pc", 64'(bus.pc_o), 64'h100);
        chk("flush bubble", 64'(bus.id_valid_o), 64'd0);
        set_in(0, 0, 1, 32'hFFFF_FFFF, 0, 0);
        step();
        chk("wrap top", 64'(bus.pc_o), 64'hFFFF_FFF8);
        set_in(0, 0, 0, 0, 0, 0);
        step();
        chk("wrap zero", 64'(bus.pc_o), 64'h0);
        chk("wrap idpc", 64'(bus.id_pc_o), 64'hFFFF_FFF8);
        set_in(0, 0, 0, 0, 1, 32'h80);
        rst_n = 1'b0;
        step();
        chk("midrst ce", 64'(bus.ce_o), 64'd0);
        chk("midrst pc", 64'(bus.pc_o), 64'h0);
        chk("midrst valid", 64'(bus.id_valid_o), 64'd0);
        chk("midrst inst", bus.id_inst_o, 64'd0);
        rst_n = 1'b1;
        set_in(0, 0, 0, 0, 0, 0);
        step();
        step();
        chk("restart inst", bus.id_inst_o, ROM0);
        for (int i = 0; i < 300; i++) begin
            set_in($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0,
                   $urandom, $urandom_range(0, 5) == 0, $urandom);
            step();
        end
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
